// File: rtl/core_alu_arbiter_if.sv
// Requester, response and ALU-side signal bundle for core_alu_arbiter.
// master = requesters/ALU side, slave = the arbiter itself.
interface core_alu_arbiter_if #(
    parameter int OPW = 5
);
    logic           req0_valid;
    logic           req0_ready;
    logic [OPW-1:0] req0_op;
    logic [31:0]    req0_rs1;
    logic [31:0]    req0_rs2;
    logic           req1_valid;
    logic           req1_ready;
    logic [OPW-1:0] req1_op;
    logic [31:0]    req1_rs1;
    logic [31:0]    req1_rs2;
    logic           resp0_valid;
    logic           resp0_ready;
    logic           resp1_valid;
    logic           resp1_ready;
    logic [31:0]    resp_result;
    logic           resp_err;
    logic           alu_start;
    logic [OPW-1:0] alu_op;
    logic [31:0]    alu_rs1;
    logic [31:0]    alu_rs2;
    logic           alu_done;
    logic [31:0]    alu_result;

    modport master (
        output req0_valid, req0_op, req0_rs1, req0_rs2,
        output req1_valid, req1_op, req1_rs1, req1_rs2,
        output resp0_ready, resp1_ready,
        output alu_done, alu_result,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp1_valid, resp_result, resp_err,
        input  alu_start, alu_op, alu_rs1, alu_rs2
    );

    modport slave (
        input  req0_valid, req0_op, req0_rs1, req0_rs2,
        input  req1_valid, req1_op, req1_rs1, req1_rs2,
        input  resp0_ready, resp1_ready,
        input  alu_done, alu_result,
        output req0_ready, req1_ready,
        output resp0_valid, resp1_valid, resp_result, resp_err,
        output alu_start, alu_op, alu_rs1, alu_rs2
    );
endinterface

// File: rtl/core_alu_arbiter.sv
// Round-robin sharing of the multi-cycle ALU between the execute pipe
// (requester 0) and the branch/address unit (requester 1), with a watchdog.
module core_alu_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int OPW     = 5
) (
    input  logic              clk,
    input  logic              rst,
    core_alu_arbiter_if.slave bus_io
);
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t         state_q, state_d;
    logic           ptr_q, ptr_d;
    logic           owner_q, owner_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [OPW-1:0] op_q, op_d;
    logic [31:0]    rs1_q, rs1_d;
    logic [31:0]    rs2_q, rs2_d;
    logic [31:0]    res_q, res_d;
    logic           err_q, err_d;

    logic           grant0;
    logic           grant1;
    logic [OPW-1:0] sel_op;
    logic [31:0]    sel_rs1;
    logic [31:0]    sel_rs2;
    logic           sel_legal;
    logic           owner_ready;

    // The pointer only breaks ties; a lone requester always wins.
    assign grant0 = bus_io.req0_valid &&
                    (!bus_io.req1_valid || !ptr_q);
    assign grant1 = bus_io.req1_valid &&
                    (!bus_io.req0_valid || ptr_q);

    assign sel_op    = grant1 ? bus_io.req1_op  : bus_io.req0_op;
    assign sel_rs1   = grant1 ? bus_io.req1_rs1 : bus_io.req0_rs1;
    assign sel_rs2   = grant1 ? bus_io.req1_rs2 : bus_io.req0_rs2;
    assign sel_legal = sel_op < OPW'(10);

    assign owner_ready = owner_q ? bus_io.resp1_ready
                                 : bus_io.resp0_ready;

    assign bus_io.req0_ready  = (state_q == IDLE) && grant0;
    assign bus_io.req1_ready  = (state_q == IDLE) && grant1;
    assign bus_io.resp0_valid = (state_q == RESP) && !owner_q;
    assign bus_io.resp1_valid = (state_q == RESP) && owner_q;
    assign bus_io.resp_result = res_q;
    assign bus_io.resp_err    = err_q;
    assign bus_io.alu_start   = (state_q == ISSUE);
    assign bus_io.alu_op      = op_q;
    assign bus_io.alu_rs1     = rs1_q;
    assign bus_io.alu_rs2     = rs2_q;

    // Next-state: accept, issue, wait with watchdog, then respond.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        res_d   = res_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    op_d    = sel_op;
                    rs1_d   = sel_rs1;
                    rs2_d   = sel_rs2;
                    owner_d = grant1;
                    if (sel_legal) begin
                        state_d = ISSUE;
                    end else begin
                        res_d   = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus_io.alu_done) begin
                    res_d   = bus_io.alu_result;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                if (owner_ready) begin
                    ptr_d   = !owner_q;
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            cnt_q   <= '0;
            op_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_core_alu_arbiter.sv
// Bench for core_alu_arbiter: directed and random operations against
// a transaction-level model of grant order, latency and results.
module tb_core_alu_arbiter;
    localparam int TIMEOUT = 16;
    localparam int OPW     = 5;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   alu_lat = 3;
    bit   ptr_m = 1'b0;

    core_alu_arbiter_if #(.OPW(OPW)) bus ();

    core_alu_arbiter #(
        .TIMEOUT(TIMEOUT),
        .OPW    (OPW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [4:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            5'd0:    return a + b;
            5'd1:    return a - b;
            5'd2:    return a << b[4:0];
            5'd3:    return {31'b0, $signed(a) < $signed(b)};
            5'd4:    return {31'b0, a < b};
            5'd5:    return a ^ b;
            5'd6:    return a >> b[4:0];
            5'd7:    return $signed(a) >>> b[4:0];
            5'd8:    return a | b;
            5'd9:    return a & b;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // ALU model: done pulse alu_lat cycles after start; 0 means hung.
    initial begin
        int          cnt;
        bit          pend;
        logic [31:0] r;
        pend = 1'b0;
        cnt  = 0;
        r    = '0;
        bus.alu_done   = 1'b0;
        bus.alu_result = '0;
        forever begin
            @(negedge clk);
            bus.alu_done = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    bus.alu_done   = 1'b1;
                    bus.alu_result = r;
                    pend           = 1'b0;
                end
            end
            if (bus.alu_start && alu_lat > 0) begin
                pend = 1'b1;
                cnt  = alu_lat;
                r    = alu_ref(bus.alu_op, bus.alu_rs1, bus.alu_rs2);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic present(input int n, input logic [4:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        if (n == 0) begin
            bus.req0_op = op; bus.req0_rs1 = a;
            bus.req0_rs2 = b; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_op = op; bus.req1_rs1 = a;
            bus.req1_rs2 = b; bus.req1_valid = 1'b1;
        end
    endtask

    task automatic withdraw(input int n);
        if (n == 0) bus.req0_valid = 1'b0;
        else        bus.req1_valid = 1'b0;
    endtask

    task automatic set_rr(input int n, input logic v);
        if (n == 0) bus.resp0_ready = v;
        else        bus.resp1_ready = v;
    endtask

    // Called at a negedge with the request(s) already presented;
    // returns at the negedge after the response handshake.
    task automatic serve(input int n, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input int bp, input string tag);
        bit          legal, tmo, busy_ok, hold_ok, bp_ok;
        int          exp_cyc, starts, start_cyc, got_cyc;
        logic        exp_err;
        logic [31:0] exp_res, res0;
        legal   = int'(op) < 10;
        tmo     = legal && (alu_lat == 0 || alu_lat > TIMEOUT);
        exp_cyc = !legal ? 1 : (tmo ? TIMEOUT + 2 : alu_lat + 2);
        exp_err = !legal || tmo;
        exp_res = exp_err ? 32'h0 : alu_ref(op, a, b);
        #1;
        chk({tag, ".grant"}, {30'b0, bus.req1_ready, bus.req0_ready},
            n != 0 ? 32'd2 : 32'd1);
        @(posedge clk);
        @(negedge clk);
        withdraw(n);
        starts = 0; start_cyc = -1; got_cyc = -1;
        busy_ok = 1'b1; hold_ok = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            if (k > 1) @(negedge clk);
            #1;
            if (bus.alu_start) begin starts++; start_cyc = k; end
            if (bus.req0_ready || bus.req1_ready) busy_ok = 1'b0;
            if (bus.alu_op !== op || bus.alu_rs1 !== a ||
                bus.alu_rs2 !== b) hold_ok = 1'b0;
            if (bus.resp0_valid || bus.resp1_valid) begin
                got_cyc = k;
                break;
            end
        end
        chk({tag, ".starts"}, starts, legal ? 32'd1 : 32'd0);
        chk({tag, ".start_cyc"}, start_cyc, legal ? 32'd1 : 32'hFFFF_FFFF);
        chk({tag, ".resp_cyc"}, got_cyc, exp_cyc);
        if (got_cyc < 0) return;
        chk({tag, ".resp_sel"}, {30'b0, bus.resp1_valid, bus.resp0_valid},
            n != 0 ? 32'd2 : 32'd1);
        chk({tag, ".result"}, bus.resp_result, exp_res);
        chk({tag, ".err"}, 32'(bus.resp_err), 32'(exp_err));
        chk({tag, ".busy_ready"}, 32'(busy_ok), 32'd1);
        chk({tag, ".op_hold"}, 32'(hold_ok), 32'd1);
        res0  = bus.resp_result;
        bp_ok = 1'b1;
        for (int k = 0; k < bp; k++) begin
            set_rr(1 - n, 1'b1);
            @(negedge clk);
            #1;
            if (!(n != 0 ? bus.resp1_valid : bus.resp0_valid) ||
                bus.resp_result !== res0 || bus.resp_err !== exp_err ||
                bus.req0_ready || bus.req1_ready) bp_ok = 1'b0;
        end
        set_rr(1 - n, 1'b0);
        if (bp > 0) chk({tag, ".backpressure"}, 32'(bp_ok), 32'd1);
        set_rr(n, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_rr(n, 1'b0);
        ptr_m = (n == 0);
        #1;
        chk({tag, ".resp_drop"},
            {30'b0, bus.resp1_valid, bus.resp0_valid}, 32'd0);
    endtask

    task automatic pair(input logic [4:0] op0, input logic [31:0] a0,
                        input logic [31:0] b0, input logic [4:0] op1,
                        input logic [31:0] a1, input logic [31:0] b1,
                        input string tag);
        int first;
        @(negedge clk);
        present(0, op0, a0, b0);
        present(1, op1, a1, b1);
        first = ptr_m ? 1 : 0;
        if (first == 0) begin
            serve(0, op0, a0, b0, 0, {tag, ".p0"});
            serve(1, op1, a1, b1, 0, {tag, ".p1"});
        end else begin
            serve(1, op1, a1, b1, 0, {tag, ".p1"});
            serve(0, op0, a0, b0, 0, {tag, ".p0"});
        end
    endtask

    task automatic single(input int n, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int bp, input string tag);
        @(negedge clk);
        present(n, op, a, b);
        serve(n, op, a, b, bp, tag);
    endtask

    initial begin
        bit quiet_ok;
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_op = '0;
        bus.req0_rs1 = '0;     bus.req0_rs2 = '0;
        bus.req1_valid = 1'b0; bus.req1_op = '0;
        bus.req1_rs1 = '0;     bus.req1_rs2 = '0;
        bus.resp0_ready = 1'b0;
        bus.resp1_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst.ctl", {28'b0, bus.alu_start, bus.resp0_valid,
                        bus.resp1_valid, bus.resp_err}, 32'd0);
        chk("rst.result", bus.resp_result, 32'd0);
        chk("rst.rs1", bus.alu_rs1, 32'd0);
        chk("rst.rs2", bus.alu_rs2, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        alu_lat = 3;
        pair(5'd1, 32'h10F08340, 32'h08000000,
             5'd5, 32'h0854AA35, 32'h0557D0BE, "rr1");
        pair(5'd8, 32'h12340000, 32'h00005678,
             5'd7, 32'h80000000, 32'd4, "rr2");
        single(0, 5'd0, 32'h09439AD4, 32'h00531794, 0, "add");
        single(0, 5'd9, 32'hF0F0A5A5, 32'h0FF0FFFF, 4, "bp");
        single(1, 5'd15, 32'h11111111, 32'h22222222, 0, "illegal");
        alu_lat = 0;
        single(0, 5'd0, 32'h00000001, 32'h00000002, 0, "hang");
        alu_lat = 16;
        single(0, 5'd0, 32'h00000003, 32'h00000004, 0, "done_last");
        alu_lat = 17;
        single(1, 5'd1, 32'h00000005, 32'h00000001, 0, "done_late");

        for (int i = 0; i < 24; i++) begin
            alu_lat = $urandom_range(1, 5);
            if ($urandom_range(0, 1) == 1)
                pair(5'($urandom_range(0, 11)), $urandom, $urandom,
                     5'($urandom_range(0, 11)), $urandom, $urandom, "rpair");
            else
                single($urandom_range(0, 1), 5'($urandom_range(0, 12)),
                       $urandom, $urandom, $urandom_range(0, 2), "rsingle");
        end

        alu_lat = 3;
        single(0, 5'd2, 32'h00000001, 32'd31, 0, "pre_rst");
        alu_lat = 8;
        @(negedge clk);
        present(0, 5'd0, 32'hCAFE0000, 32'h0000BEEF);
        @(posedge clk);
        @(negedge clk);
        withdraw(0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst.ctl", {28'b0, bus.alu_start, bus.resp0_valid,
                         bus.resp1_valid, bus.resp_err}, 32'd0);
        chk("arst.result", bus.resp_result, 32'd0);
        chk("arst.rs1", bus.alu_rs1, 32'd0);
        chk("arst.rs2", bus.alu_rs2, 32'd0);
        ptr_m = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        quiet_ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            if (bus.resp0_valid || bus.resp1_valid || bus.alu_start)
                quiet_ok = 1'b0;
        end
        chk("arst.stray_done", 32'(quiet_ok), 32'd1);
        alu_lat = 2;
        pair(5'd4, 32'h00000001, 32'hFFFFFFFF,
             5'd3, 32'hFFFFFFFF, 32'h00000001, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
